multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Next-generation RV32I control for the multicycle datapath. It replaces the single-cycle opcode decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback.
- It drives a shared instruction/data memory through a req/ready handshake and keeps the existing per-instruction control set (Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp).
- It adds PC/IR write strobes and a retired-instruction counter.
- It sits between the instruction register and the datapath muxes/ALU control.

Parameters:
- ALUOP_W, 2, width of alu_op. Must be >= 2; bits above [1:0] are always 0.
- CNT_W, 32, width of instr_retired.
- NOP_OPCODE, 7'b0000000, opcode that retires with no datapath activity.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]; sampled only in DECODE
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data)
- pc_write  out  1  PC <= PC+4 this cycle
- ir_write  out  1  IR <= memory read data this cycle
- branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  datapath controls
- alu_op  out  ALUOP_W  00 add, 01 sub/compare, 10 funct-decoded
- state  out  3  current FSM state (debug)
- instr_retired  out  CNT_W  retired-instruction count
- illegal_instr  out  1  only with the optional feature

Behaviour:
- Clocking/reset: one clock domain, clk. Reset is synchronous and active-high on reset.
- While reset is high at a clock edge: state <= FETCH, op_q <= NOP_OPCODE, instr_retired <= 0. All outputs are forced 0 during the reset-asserted cycle.
- Reset mid-operation: abandons any outstanding request the next cycle; no partial writes (reg_write/mem_write drop).
- Outputs: Moore, decoded from state and op_q. op_q is latched in DECODE; opcode is ignored elsewhere. Every control not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

FETCH:
- mem_req=1, mem_addr_sel=0, mem_read=1.
- On mem_ready: ir_write=1, pc_write=1 (same cycle), -> DECODE. Otherwise stay.

DECODE:
- op_q <= opcode.
- NOP_OPCODE: retire, -> FETCH.
- 0000011 / 0100011 / 0110011 / 1100011 / 0010011: -> EXEC.
- Any other opcode: illegal, see Optional Feature.

EXEC (by op_q):
- load/store: alu_src=1, alu_op=00.
- R-type: alu_src=0, alu_op=10.
- I-ALU: alu_src=1, alu_op=00.
- branch: alu_op=01, branch=1 (single cycle); retire -> FETCH.
- Next state: load/store -> MEM; R-type/I-ALU -> WB.

MEM:
- mem_req=1, mem_addr_sel=1, alu_src=1.
- Load: mem_read=1. On mem_ready -> WB.
- Store: mem_write=1. On mem_ready, retire -> FETCH.
- mem_ready low: hold all outputs.

WB:
- reg_write=1 for one cycle; mem_to_reg=1 for load, 0 otherwise. Retire -> FETCH.

Handshake and counting:
- mem_req never drops before mem_ready. mem_ready is ignored outside FETCH/MEM.
- Retire means instr_retired increments by 1 on the transition edge into FETCH. It wraps modulo 2^CNT_W.
- Latency with mem_ready always high, in cycles per instruction: NOP 2, branch 3, R/I-ALU 4, store 4, load 5. Each wait cycle adds 1.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE -> TRAP. TRAP drives illegal_instr=1 and all other controls 0, does not retire, and holds until reset. The illegal_instr port exists only when the macro is defined.
- Undefined: an illegal opcode is treated as NOP_OPCODE (retires, -> FETCH). There is no illegal_instr port and TRAP is unreachable.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams: OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_IALU, OP_NOP;
  - the state enum/encodings;
  - ALUOp encodings ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
- Sub-module main_decoder: combinational, op_q -> static controls (alu_src, mem_to_reg, alu_op, is_load/is_store/is_branch/is_alu/is_legal). The FSM gates these by state.

Test Plan:
- R-type (0110011), mem_ready tied 1 -> states 0,1,2,4,0. ir_write/pc_write in cycle 1 only; reg_write=1 and alu_op=10 in WB; instr_retired 0 -> 1.
- Load (0000011), fetch and data mem_ready each delayed 3 cycles -> mem_req held 4 cycles in FETCH and 4 in MEM. mem_read=1 throughout MEM; WB has mem_to_reg=1 and reg_write=1; 11 cycles total.
- Branch (1100011) then store (0100011) -> branch=1 and alu_op=01 for exactly one EXEC cycle. Store has mem_write=1 in MEM and reg_write never 1; count +2.
- Reset asserted in MEM of a store with mem_ready=0 -> next cycle state=0, mem_write=0, instr_retired=0. Store is not counted.
- Opcode 7'b1111111, with and without CTRL_ILLEGAL_TRAP_EN:
  - defined -> state=5, illegal_instr=1 held for 20 cycles, count unchanged;
  - undefined -> retires in 2 cycles.
- CNT_W=4, 17 NOPs -> instr_retired reads 15 then 0 then 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, FSM state encodings and ALUOp codes shared by the multicycle control unit.
package ctrl_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_NOP    = 7'b0000000;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/main_decoder.sv
// main_decoder: static per-opcode controls and instruction class flags; the FSM gates them by state.
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic [1:0] alu_op,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_alu,
    output logic       is_legal
);
    always_comb begin
        is_load    = op == OP_LOAD;
        is_store   = op == OP_STORE;
        is_branch  = op == OP_BRANCH;
        is_alu     = op == OP_RTYPE || op == OP_IALU;
        is_legal   = is_load || is_store || is_branch || is_alu;
        alu_src    = is_load || is_store || op == OP_IALU;
        mem_to_reg = is_load;
        alu_op     = op == OP_RTYPE ? ALUOP_FUNCT : is_branch ? ALUOP_SUB : ALUOP_ADD;
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I Moore FSM sequencing fetch/decode/exec/mem/wb over a shared memory.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes (adds illegal_instr); otherwise they retire as NOPs.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int         ALUOP_W    = 2,
    parameter int         CNT_W      = 32,
    parameter logic [6:0] NOP_OPCODE = OP_NOP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_addr_sel,
    output logic               pc_write,
    output logic               ir_write,
    output logic               branch,
    output logic               mem_read,
    output logic               mem_to_reg,
    output logic               mem_write,
    output logic               alu_src,
    output logic               reg_write,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic               illegal_instr,
`endif
    output logic [CNT_W-1:0]   instr_retired
);
    state_e           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic [1:0]       aop;
    logic             d_alu_src, d_mem_to_reg, is_load, is_store, is_branch, is_alu, is_legal;
    logic [1:0]       d_alu_op;

    assign op_d = state_q == S_DECODE ? opcode : op_q;

    // Decoding op_d lets DECODE branch on the live opcode; later states see op_q unchanged.
    main_decoder u_dec (
        .op(op_d), .alu_src(d_alu_src), .mem_to_reg(d_mem_to_reg), .alu_op(d_alu_op),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_alu(is_alu),
        .is_legal(is_legal)
    );

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        branch       = 1'b0;
        mem_read     = 1'b0;
        mem_to_reg   = 1'b0;
        mem_write    = 1'b0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        aop          = ALUOP_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
                state_d  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (op_d != NOP_OPCODE && is_legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = op_d == NOP_OPCODE ? S_FETCH : S_TRAP;
                    retire  = op_d == NOP_OPCODE;
`else
                    state_d = S_FETCH;
                    retire  = 1'b1;
`endif
                end
            end
            S_EXEC: begin
                alu_src = d_alu_src;
                aop     = d_alu_op;
                branch  = is_branch;
                retire  = is_branch;
                state_d = is_branch ? S_FETCH : is_alu ? S_WB : S_MEM;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                alu_src      = 1'b1;
                mem_read     = is_load;
                mem_write    = is_store;
                retire       = mem_ready && is_store;
                state_d      = !mem_ready ? S_MEM : is_load ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = d_mem_to_reg;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: illegal_instr = 1'b1;
`endif
            default: state_d = S_FETCH;
        endcase
        cnt_d = cnt_q + CNT_W'(retire);
        // Nothing escapes during the reset cycle, so a half-finished store never reaches memory.
        if (reset) begin
            mem_req      = 1'b0;
            mem_addr_sel = 1'b0;
            pc_write     = 1'b0;
            ir_write     = 1'b0;
            branch       = 1'b0;
            mem_read     = 1'b0;
            mem_to_reg   = 1'b0;
            mem_write    = 1'b0;
            alu_src      = 1'b0;
            reg_write    = 1'b0;
            aop          = ALUOP_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_instr = 1'b0;
`endif
        end
    end

    assign alu_op        = ALUOP_W'(aop);
    assign state         = reset ? 3'd0 : state_q;
    assign instr_retired = reset ? '0 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= NOP_OPCODE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
